// File: rtl/mult_acc_pipe.sv
// Pipelined multiply-accumulate: optional input register, accumulator with wrap/saturate
// and sticky overflow, optional output register. Latency IREG + 1 + OREG.
module mult_acc_pipe #(
  parameter int unsigned A_WIDTH   = 8,
  parameter int unsigned B_WIDTH   = 8,
  parameter int unsigned ACC_WIDTH = 20,
  parameter int unsigned IREG      = 1,
  parameter int unsigned OREG      = 1,
  parameter int unsigned SATURATE  = 0
) (
  input  logic                 CLK,
  input  logic                 RST_N,
  input  logic                 VALID_IN,
  input  logic [A_WIDTH-1:0]   A,
  input  logic [B_WIDTH-1:0]   B,
  input  logic                 SIGNED,
  input  logic                 LOAD,
  input  logic                 ACC_EN,
  output logic                 VALID_OUT,
  output logic [ACC_WIDTH-1:0] Z,
  output logic                 OVF
);

  localparam int unsigned MSB = ACC_WIDTH - 1;

  generate
    if (ACC_WIDTH < A_WIDTH + B_WIDTH) begin : g_width_check
      $error("mult_acc_pipe: ACC_WIDTH must be >= A_WIDTH + B_WIDTH");
    end
  endgenerate

  logic               s_valid;
  logic [A_WIDTH-1:0] s_a;
  logic [B_WIDTH-1:0] s_b;
  logic               s_sg;
  logic               s_ld;
  logic               s_en;

  generate
    if (IREG != 0) begin : g_ireg
      always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
          s_valid <= 1'b0;
          s_a     <= '0;
          s_b     <= '0;
          s_sg    <= 1'b0;
          s_ld    <= 1'b0;
          s_en    <= 1'b0;
        end else begin
          s_valid <= VALID_IN;
          s_a     <= A;
          s_b     <= B;
          s_sg    <= SIGNED;
          s_ld    <= LOAD;
          s_en    <= ACC_EN;
        end
      end
    end else begin : g_no_ireg
      assign s_valid = VALID_IN;
      assign s_a     = A;
      assign s_b     = B;
      assign s_sg    = SIGNED;
      assign s_ld    = LOAD;
      assign s_en    = ACC_EN;
    end
  endgenerate

  // Operands are extended to ACC_WIDTH first; the low ACC_WIDTH bits of that product
  // equal the correctly sign/zero-extended full-precision product.
  logic [ACC_WIDTH-1:0] a_ext;
  logic [ACC_WIDTH-1:0] b_ext;
  logic [ACC_WIDTH-1:0] prod;

  assign a_ext = {{(ACC_WIDTH-A_WIDTH){s_sg & s_a[A_WIDTH-1]}}, s_a};
  assign b_ext = {{(ACC_WIDTH-B_WIDTH){s_sg & s_b[B_WIDTH-1]}}, s_b};
  assign prod  = a_ext * b_ext;

  logic [ACC_WIDTH-1:0] acc;
  logic                 acc_ovf;
  logic                 acc_valid;
  logic [ACC_WIDTH:0]   sum;
  logic                 add_ovf;
  logic [ACC_WIDTH-1:0] sat_val;
  logic [ACC_WIDTH-1:0] add_res;

  assign sum = {1'b0, acc} + {1'b0, prod};

  always_comb begin
    add_ovf = 1'b0;
    sat_val = '1;
    add_res = sum[MSB:0];
    if (s_sg) begin
      add_ovf = (acc[MSB] == prod[MSB]) && (sum[MSB] != acc[MSB]);
      sat_val = prod[MSB] ? {1'b1, {MSB{1'b0}}} : {1'b0, {MSB{1'b1}}};
    end else begin
      add_ovf = sum[ACC_WIDTH];
    end
    if ((SATURATE != 0) && add_ovf) begin
      add_res = sat_val;
    end
  end

  // Plain multiply (ACC_EN=0, LOAD=0) replaces acc but leaves the sticky flag alone.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      acc       <= '0;
      acc_ovf   <= 1'b0;
      acc_valid <= 1'b0;
    end else begin
      acc_valid <= s_valid;
      if (s_valid) begin
        if (s_ld || !s_en) begin
          acc <= prod;
        end else begin
          acc <= add_res;
        end
        if (s_ld) begin
          acc_ovf <= 1'b0;
        end else if (s_en) begin
          acc_ovf <= acc_ovf | add_ovf;
        end
      end
    end
  end

  generate
    if (OREG != 0) begin : g_oreg
      always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
          VALID_OUT <= 1'b0;
          Z         <= '0;
          OVF       <= 1'b0;
        end else begin
          VALID_OUT <= acc_valid;
          Z         <= acc;
          OVF       <= acc_ovf;
        end
      end
    end else begin : g_no_oreg
      assign VALID_OUT = acc_valid;
      assign Z         = acc;
      assign OVF       = acc_ovf;
    end
  endgenerate

endmodule

// File: tb/tb_mult_acc_pipe.sv
// Directed bench for mult_acc_pipe: default wrap, saturating, and IREG=0/OREG=0 instances
// share one stimulus stream and are checked against hand-computed values.
module tb_mult_acc_pipe;

  logic        CLK;
  logic        RST_N;
  logic        VALID_IN;
  logic [7:0]  A;
  logic [7:0]  B;
  logic        SIGNED;
  logic        LOAD;
  logic        ACC_EN;

  logic        wrap_vo,  sat_vo,  comb_vo;
  logic [19:0] wrap_z,   sat_z,   comb_z;
  logic        wrap_ovf, sat_ovf, comb_ovf;

  int n_chk = 0;
  int n_err = 0;

  mult_acc_pipe u_wrap (
    .CLK(CLK), .RST_N(RST_N), .VALID_IN(VALID_IN), .A(A), .B(B),
    .SIGNED(SIGNED), .LOAD(LOAD), .ACC_EN(ACC_EN),
    .VALID_OUT(wrap_vo), .Z(wrap_z), .OVF(wrap_ovf)
  );

  mult_acc_pipe #(.SATURATE(1)) u_sat (
    .CLK(CLK), .RST_N(RST_N), .VALID_IN(VALID_IN), .A(A), .B(B),
    .SIGNED(SIGNED), .LOAD(LOAD), .ACC_EN(ACC_EN),
    .VALID_OUT(sat_vo), .Z(sat_z), .OVF(sat_ovf)
  );

  mult_acc_pipe #(.IREG(0), .OREG(0)) u_comb (
    .CLK(CLK), .RST_N(RST_N), .VALID_IN(VALID_IN), .A(A), .B(B),
    .SIGNED(SIGNED), .LOAD(LOAD), .ACC_EN(ACC_EN),
    .VALID_OUT(comb_vo), .Z(comb_z), .OVF(comb_ovf)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Inputs change on the falling edge; outputs are inspected at the same falling edge.
  task automatic drive(input logic v, input logic [7:0] a, input logic [7:0] b,
                       input logic sg, input logic ld, input logic en);
    @(negedge CLK);
    VALID_IN = v;
    A        = a;
    B        = b;
    SIGNED   = sg;
    LOAD     = ld;
    ACC_EN   = en;
  endtask

  task automatic idle();
    drive(1'b0, 8'd0, 8'd0, 1'b0, 1'b0, 1'b0);
  endtask

  initial begin
    int pulses;
    RST_N    = 1'b0;
    VALID_IN = 1'b0;
    A        = '0;
    B        = '0;
    SIGNED   = 1'b0;
    LOAD     = 1'b0;
    ACC_EN   = 1'b0;

    #12;
    check("rst_z",   32'(wrap_z),   32'd0);
    check("rst_vo",  32'(wrap_vo),  32'd0);
    check("rst_ovf", 32'(wrap_ovf), 32'd0);
    @(negedge CLK);
    RST_N = 1'b1;

    // Unsigned MAC
    drive(1, 8'd255, 8'd255, 0, 1, 0);
    drive(1, 8'd255, 8'd255, 0, 0, 1);
    idle();
    idle();
    check("umac1_vo",  32'(wrap_vo),  32'd1);
    check("umac1_z",   32'(wrap_z),   32'd65025);
    check("umac1_ovf", 32'(wrap_ovf), 32'd0);
    idle();
    check("umac2_vo",  32'(wrap_vo),  32'd1);
    check("umac2_z",   32'(wrap_z),   32'd130050);
    check("umac2_ovf", 32'(wrap_ovf), 32'd0);
    idle();
    check("umac_hold_vo", 32'(wrap_vo), 32'd0);
    check("umac_hold_z",  32'(wrap_z),  32'd130050);

    // Signed plain multiply
    drive(1, 8'h80, 8'h7F, 1, 0, 0);
    drive(1, 8'hFF, 8'hFF, 1, 0, 0);
    idle();
    idle();
    check("smul1_vo", 32'(wrap_vo), 32'd1);
    check("smul1_z",  32'(wrap_z),  32'h000FC080);
    idle();
    check("smul2_z",   32'(wrap_z),   32'd1);
    check("smul2_ovf", 32'(wrap_ovf), 32'd0);

    // Unsigned overflow: wrap vs saturate, sticky flag, cleared by LOAD
    for (int i = 0; i < 25; i++) begin
      if (i == 0)       drive(1, 8'd255, 8'd255, 0, 1, 0);
      else if (i <= 16) drive(1, 8'd255, 8'd255, 0, 0, 1);
      else if (i == 20) drive(1, 8'd1,   8'd1,   0, 0, 1);
      else if (i == 21) drive(1, 8'd2,   8'd3,   0, 1, 0);
      else              idle();
      if (i == 18) begin
        check("uov16_wrap_z",   32'(wrap_z),   32'd1040400);
        check("uov16_wrap_ovf", 32'(wrap_ovf), 32'd0);
        check("uov16_sat_z",    32'(sat_z),    32'd1040400);
      end
      if (i == 19) begin
        check("uov17_wrap_z",   32'(wrap_z),   32'd56849);
        check("uov17_wrap_ovf", 32'(wrap_ovf), 32'd1);
        check("uov17_sat_z",    32'(sat_z),    32'h000FFFFF);
        check("uov17_sat_ovf",  32'(sat_ovf),  32'd1);
      end
      if (i == 22) begin
        check("uov_gap_vo", 32'(wrap_vo), 32'd0);
        check("uov_gap_z",  32'(wrap_z),  32'd56849);
      end
      if (i == 23) begin
        check("uov_sticky_wrap_z",   32'(wrap_z),   32'd56850);
        check("uov_sticky_wrap_ovf", 32'(wrap_ovf), 32'd1);
        check("uov_sticky_sat_z",    32'(sat_z),    32'h000FFFFF);
        check("uov_sticky_sat_ovf",  32'(sat_ovf),  32'd1);
      end
      if (i == 24) begin
        check("uov_load_wrap_z",   32'(wrap_z),   32'd6);
        check("uov_load_wrap_ovf", 32'(wrap_ovf), 32'd0);
        check("uov_load_sat_ovf",  32'(sat_ovf),  32'd0);
      end
    end

    // Signed overflow toward min negative
    for (int i = 0; i < 36; i++) begin
      if (i == 0)       drive(1, 8'h80, 8'h7F, 1, 1, 0);
      else if (i <= 32) drive(1, 8'h80, 8'h7F, 1, 0, 1);
      else              idle();
      if (i == 34) begin
        check("sov32_sat_z",   32'(sat_z),    32'h00081000);
        check("sov32_sat_ovf", 32'(sat_ovf),  32'd0);
        check("sov32_wrap_z",  32'(wrap_z),   32'h00081000);
      end
      if (i == 35) begin
        check("sov33_sat_z",    32'(sat_z),    32'h00080000);
        check("sov33_sat_ovf",  32'(sat_ovf),  32'd1);
        check("sov33_wrap_z",   32'(wrap_z),   32'h0007D080);
        check("sov33_wrap_ovf", 32'(wrap_ovf), 32'd1);
      end
    end

    // Reset asserted between edges while results are in flight
    drive(1, 8'd1, 8'd1, 0, 0, 1);
    drive(1, 8'd1, 8'd1, 0, 0, 1);
    drive(1, 8'd1, 8'd1, 0, 0, 1);
    idle();
    check("pre_rst_wrap_vo",  32'(wrap_vo),  32'd1);
    check("pre_rst_wrap_z",   32'(wrap_z),   32'h0007D081);
    check("pre_rst_wrap_ovf", 32'(wrap_ovf), 32'd1);
    check("pre_rst_comb_z",   32'(comb_z),   32'h0007D083);
    #2;
    RST_N = 1'b0;
    #1;
    check("arst_wrap_z",   32'(wrap_z),   32'd0);
    check("arst_wrap_vo",  32'(wrap_vo),  32'd0);
    check("arst_wrap_ovf", 32'(wrap_ovf), 32'd0);
    check("arst_sat_z",    32'(sat_z),    32'd0);
    check("arst_comb_z",   32'(comb_z),   32'd0);
    check("arst_comb_ovf", 32'(comb_ovf), 32'd0);
    idle();
    RST_N = 1'b1;
    for (int i = 0; i < 3; i++) begin
      idle();
      check("post_rst_wrap_vo", 32'(wrap_vo), 32'd0);
      check("post_rst_comb_vo", 32'(comb_vo), 32'd0);
    end
    drive(1, 8'd2, 8'd2, 0, 0, 1);
    idle();
    check("fresh_comb_vo", 32'(comb_vo), 32'd1);
    check("fresh_comb_z",  32'(comb_z),  32'd4);
    check("fresh_wrap_vo", 32'(wrap_vo), 32'd0);
    idle();
    check("fresh_comb_vo_pulse", 32'(comb_vo), 32'd0);
    idle();
    check("fresh_wrap_vo2",  32'(wrap_vo),  32'd1);
    check("fresh_wrap_z",    32'(wrap_z),   32'd4);
    check("fresh_wrap_ovf",  32'(wrap_ovf), 32'd0);

    // Valid gaps: LOAD ignored while VALID_IN=0
    pulses = 0;
    drive(1, 8'd3, 8'd4, 0, 1, 0);
    check("gap_pre_vo", 32'(wrap_vo), 32'd0);
    drive(0, 8'd7, 8'd7, 0, 1, 0);
    pulses += int'(wrap_vo);
    check("gap_comb1_vo", 32'(comb_vo), 32'd1);
    check("gap_comb1_z",  32'(comb_z),  32'd12);
    drive(0, 8'd7, 8'd7, 0, 1, 0);
    pulses += int'(wrap_vo);
    check("gap_comb2_vo", 32'(comb_vo), 32'd0);
    drive(1, 8'd5, 8'd6, 0, 0, 1);
    pulses += int'(wrap_vo);
    check("gap1_vo", 32'(wrap_vo), 32'd1);
    check("gap1_z",  32'(wrap_z),  32'd12);
    idle();
    pulses += int'(wrap_vo);
    check("gap_hold1_z", 32'(wrap_z),  32'd12);
    check("gap_comb3_z", 32'(comb_z),  32'd42);
    idle();
    pulses += int'(wrap_vo);
    check("gap_hold2_z", 32'(wrap_z), 32'd12);
    idle();
    pulses += int'(wrap_vo);
    check("gap2_vo", 32'(wrap_vo), 32'd1);
    check("gap2_z",  32'(wrap_z),  32'd42);
    idle();
    pulses += int'(wrap_vo);
    check("gap_hold3_z", 32'(wrap_z), 32'd42);
    check("gap_pulses",  32'(pulses), 32'd2);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule

// File: doc/mult_acc_pipe.md
Name: mult_acc_pipe

Overview:
Parametrised, pipelined multiply-accumulate block. It is the general form of the fixed 8x8 registered multipliers used as DSP inference and packing test cases.
- Operand width, signedness, input/output register stages, accumulation, and wrap/saturate behaviour are all configurable.
- Each operand pair is qualified by a valid strobe.
- Sits between operand producers and downstream logic as the DSP-mappable arithmetic unit.

Parameters:
A_WIDTH, 8, width of operand A
B_WIDTH, 8, width of operand B
ACC_WIDTH, 20, accumulator/result width; must be >= A_WIDTH+B_WIDTH (elaboration error otherwise)
IREG, 1, 1 = register A/B/SIGNED/LOAD/ACC_EN/VALID_IN before multiply; 0 = combinational into multiplier
OREG, 1, 1 = extra output register after accumulator; 0 = Z driven from accumulator register
SATURATE, 0, 1 = clamp accumulator on overflow; 0 = wrap modulo 2^ACC_WIDTH

Ports:
CLK  input  1  clock, all state on rising edge
RST_N  input  1  asynchronous active-low reset
VALID_IN  input  1  operand pair valid this cycle
A  input  A_WIDTH  operand A
B  input  B_WIDTH  operand B
SIGNED  input  1  1 = A, B and the accumulation are two's complement; 0 = unsigned; sampled with operands
LOAD  input  1  start new accumulation: acc <= product; clears OVF
ACC_EN  input  1  1 = acc <= acc + product; 0 = acc <= product (plain multiply)
VALID_OUT  output  1  Z updated with a new result this cycle
Z  output  ACC_WIDTH  accumulator/result
OVF  output  1  sticky overflow flag since the last LOAD

Behaviour:
- Clock and reset: one clock, CLK. Reset RST_N is asynchronous and active-low.
- Reset (asynchronous, RST_N=0): every register goes to 0 immediately, including the accumulator, Z, VALID_OUT, OVF and the input/output stage registers. In-flight operands are discarded. The first valid after reset release behaves as a fresh start with acc=0.
- Stage 0 (IREG=1): registers the control/data group {VALID_IN, A, B, SIGNED, LOAD, ACC_EN} every cycle.
- Product:
  - Full-precision A*B of width A_WIDTH+B_WIDTH.
  - Signed when SIGNED=1, unsigned otherwise.
  - Sign- or zero-extended to ACC_WIDTH according to SIGNED.
- Accumulator stage (always present), on a valid sample:
  - LOAD=1 or ACC_EN=0: acc <= ext(product). LOAD dominates ACC_EN.
  - Otherwise: acc <= acc + ext(product).
  - On an invalid cycle, acc holds and LOAD/ACC_EN are ignored.
- Overflow detection (addition only, never on load):
  - SIGNED=1: the operands share a sign and the sum sign differs.
  - SIGNED=0: carry out of bit ACC_WIDTH-1.
  - SIGNED is evaluated per sample; switching mode mid-accumulation is legal and the current sample's mode applies.
- SATURATE=1 on overflow:
  - Unsigned: clamp to 2^ACC_WIDTH-1.
  - Signed: clamp to max positive or min negative according to the sign of the addend.
- SATURATE=0: result wraps.
- OVF:
  - Set on any overflow and remains set until a valid LOAD.
  - A LOAD sample clears it, even if that sample is itself a load.
  - Updated at the same stage as acc and delayed through the output register alongside Z.
- Output stage (OREG=1): Z, OVF and VALID_OUT are registered copies of the acc, OVF and valid of the accumulator stage.
- Latency: VALID_IN to VALID_OUT/Z = IREG + 1 + OREG cycles (default 3).
  - Fully pipelined; one sample accepted per cycle with no stall or backpressure.
- Z and OVF hold their value when VALID_OUT=0.
- VALID_OUT is a one-cycle pulse per accepted sample.

Test Plan:
(defaults A=B=8, ACC_WIDTH=20, IREG=OREG=1)
1. Unsigned MAC: SIGNED=0. Cycle 0: VALID_IN=1, LOAD=1, A=B=255. Cycle 1: VALID_IN=1, ACC_EN=1, LOAD=0, A=B=255.
   -> VALID_OUT at cycles 3 and 4; Z=65025, then 130050; OVF=0.
2. Signed multiply: SIGNED=1, ACC_EN=0, A=-128, B=127 -> after 3 cycles Z=20'hFC080 (-16256).
   Follow with A=-1, B=-1 -> Z=1.
3. Wrap overflow: SATURATE=0. LOAD 255*255, then 16 further accumulates of 255*255.
   -> final Z=56849; OVF rises on the 17th result; OVF stays 1 until the next LOAD, which yields OVF=0.
4. Saturation: same stimulus as scenario 3 with SATURATE=1 -> Z=20'hFFFFF, OVF=1.
   Signed case: SIGNED=1, repeat (-128)*127 until overflow -> Z=20'h80000.
5. Valid gaps and ignored controls:
   - LOAD 3*4.
   - Idle 2 cycles with LOAD=1 but VALID_IN=0.
   - Accumulate 5*6.
   -> Z=12, then 42; VALID_OUT pulses only twice; Z holds between pulses.
6. Reset mid-operation: accumulate three samples, then pull RST_N low between clock edges while results are in flight.
   -> Z, VALID_OUT and OVF go to 0 without waiting for a clock edge; no stale VALID_OUT after release.
   Then accumulate 2*2 with LOAD=0, ACC_EN=1 -> Z=4.
   Repeat with IREG=0, OREG=0 and check 1-cycle latency.
